// File: rtl/coincidence_scanner.sv
// Hardware sequencer for the coincidence recorder CSR port: acquire, read back
// one channel's histogram, find the single rising edge, program the coincidence point.
module coincidence_scanner #(
  parameter int SAMPLE_CLKS_PER_COINCIDENCE = 80,
  parameter int SUM_WIDTH                   = 8,
  parameter int MUXSEL_WIDTH                = 1,
  parameter int THRESHOLD                   = 64,
  parameter int READ_SETTLE                 = 16,
  parameter int TIMEOUT_CYCLES              = 16777215,
  localparam int AW = $clog2(SAMPLE_CLKS_PER_COINCIDENCE)
) (
  input  logic                    sysClk,
  input  logic                    sysReset,
  input  logic                    start,
  input  logic [MUXSEL_WIDTH-1:0] channel,
  input  logic [AW-1:0]           offset,
  input  logic                    realignEnable,
  output logic                    sysCsrStrobe,
  output logic [31:0]             sysGPIO_OUT,
  input  logic [31:0]             sysCsr,
  output logic                    scanBusy,
  output logic                    done,
  output logic                    error,
  output logic                    timedOut,
  output logic [AW-1:0]           edgeAddress,
  output logic [3:0]              edgeCount
);

  localparam int N  = SAMPLE_CLKS_PER_COINCIDENCE;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(READ_SETTLE + 1);

  typedef enum logic [3:0] {
    IDLE, ARM, WAIT_RISE, WAIT_FALL, READ_REQ, READ_WAIT,
    EVAL, PROGRAM, POST_PROGRAM, REALIGN, FINISH
  } stateT;

  stateT                   state;
  logic [MUXSEL_WIDTH-1:0] channelLat;
  logic [AW-1:0]           offsetLat;
  logic                    realignLat;
  logic [TW-1:0]           timer;
  logic [SW-1:0]           settleCnt;
  logic [AW:0]             readIndex;
  logic [AW-1:0]           readAddr;
  logic                    prevHi;

  logic [AW-1:0] reqAddr;
  logic [AW:0]   progSum;
  logic [AW-1:0] progAddr;
  logic          binHi;
  logic          timerExpired;
  logic [31:0]   readWord;
  logic [31:0]   progWord;
  logic          unusedCsrBits;

  // First read fetches the last bin so the wrap edge at address 0 is seen.
  assign reqAddr      = (readIndex == '0) ? AW'(N - 1) : AW'(readIndex - 1'b1);
  assign progSum      = {1'b0, edgeAddress} + {1'b0, offsetLat};
  assign progAddr     = (progSum >= (AW+1)'(N)) ? AW'(progSum - (AW+1)'(N)) : progSum[AW-1:0];
  assign binHi        = sysCsr[SUM_WIDTH-1:0] >= SUM_WIDTH'(THRESHOLD);
  assign timerExpired = timer == TW'(TIMEOUT_CYCLES);
  assign unusedCsrBits = ^sysCsr[30:SUM_WIDTH];

  always_comb begin
    readWord = '0;
    readWord[24 +: MUXSEL_WIDTH] = channelLat;
    readWord[AW-1:0] = reqAddr;
    progWord = '0;
    progWord[30] = 1'b1;
    progWord[AW-1:0] = progAddr;
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state        <= IDLE;
      sysCsrStrobe <= 1'b0;
      sysGPIO_OUT  <= '0;
      scanBusy     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      timedOut     <= 1'b0;
      edgeAddress  <= '0;
      edgeCount    <= '0;
      channelLat   <= '0;
      offsetLat    <= '0;
      realignLat   <= 1'b0;
      timer        <= '0;
      settleCnt    <= '0;
      readIndex    <= '0;
      readAddr     <= '0;
      prevHi       <= 1'b0;
    end else begin
      sysCsrStrobe <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: if (start) begin
          channelLat  <= channel;
          offsetLat   <= offset;
          realignLat  <= realignEnable;
          edgeCount   <= '0;
          edgeAddress <= '0;
          error       <= 1'b0;
          timedOut    <= 1'b0;
          scanBusy    <= 1'b1;
          state       <= ARM;
        end
        ARM: begin
          sysCsrStrobe <= 1'b1;
          sysGPIO_OUT  <= 32'h8000_0000;
          timer        <= '0;
          state        <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (sysCsr[31]) begin
            timer <= '0;
            state <= WAIT_FALL;
          end else if (timerExpired) begin
            error    <= 1'b1;
            timedOut <= 1'b1;
            state    <= FINISH;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_FALL: begin
          if (!sysCsr[31]) begin
            readIndex <= '0;
            state     <= READ_REQ;
          end else if (timerExpired) begin
            error    <= 1'b1;
            timedOut <= 1'b1;
            state    <= FINISH;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        READ_REQ: begin
          sysCsrStrobe <= 1'b1;
          sysGPIO_OUT  <= readWord;
          readAddr     <= reqAddr;
          settleCnt    <= '0;
          state        <= READ_WAIT;
        end
        READ_WAIT: begin
          if (settleCnt == SW'(READ_SETTLE - 1)) begin
            if (readIndex != '0 && binHi && !prevHi) begin
              edgeAddress <= readAddr;
              if (edgeCount != 4'hF) edgeCount <= edgeCount + 1'b1;
            end
            prevHi <= binHi;
            if (readIndex == (AW+1)'(N)) begin
              state <= EVAL;
            end else begin
              readIndex <= readIndex + 1'b1;
              state     <= READ_REQ;
            end
          end else begin
            settleCnt <= settleCnt + 1'b1;
          end
        end
        EVAL: begin
          if (edgeCount != 4'd1) begin
            error <= 1'b1;
            state <= FINISH;
          end else begin
            state <= PROGRAM;
          end
        end
        PROGRAM: begin
          sysCsrStrobe <= 1'b1;
          sysGPIO_OUT  <= progWord;
          state        <= POST_PROGRAM;
        end
        // Spacer cycle keeps the program and realign strobes apart.
        POST_PROGRAM: state <= realignLat ? REALIGN : FINISH;
        REALIGN: begin
          sysCsrStrobe <= 1'b1;
          sysGPIO_OUT  <= 32'h2000_0000;
          state        <= FINISH;
        end
        FINISH: begin
          done     <= 1'b1;
          scanBusy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coincidence_scanner.sv
// Scoreboard bench for coincidence_scanner: a small recorder model answers the CSR
// strobes while a monitor checks every strobe word and every done result.
module tb_coincidence_scanner;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          sysClk = 1'b0;
  logic          sysReset = 1'b1;
  logic          start = 1'b0;
  logic [0:0]    channel = 1'b0;
  logic [AW-1:0] offset = '0;
  logic          realignEnable = 1'b0;
  logic          sysCsrStrobe;
  logic [31:0]   sysGPIO_OUT;
  logic [31:0]   sysCsr;
  logic          scanBusy, done, error, timedOut;
  logic [AW-1:0] edgeAddress;
  logic [3:0]    edgeCount;

  always #5 sysClk = ~sysClk;

  coincidence_scanner #(
    .SAMPLE_CLKS_PER_COINCIDENCE(N),
    .SUM_WIDTH(8),
    .MUXSEL_WIDTH(1),
    .THRESHOLD(4),
    .READ_SETTLE(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .sysClk(sysClk),
    .sysReset(sysReset),
    .start(start),
    .channel(channel),
    .offset(offset),
    .realignEnable(realignEnable),
    .sysCsrStrobe(sysCsrStrobe),
    .sysGPIO_OUT(sysGPIO_OUT),
    .sysCsr(sysCsr),
    .scanBusy(scanBusy),
    .done(done),
    .error(error),
    .timedOut(timedOut),
    .edgeAddress(edgeAddress),
    .edgeCount(edgeCount)
  );

  // Recorder model: busy pulse after an acquire command, bin data after a 4-cycle lag.
  logic [7:0] binsMem [N];
  logic       busyOn = 1'b1;
  int         acqCnt = 0;
  logic [7:0] lag0 = '0, lag1 = '0, lag2 = '0;

  always @(posedge sysClk) begin
    if (sysCsrStrobe && sysGPIO_OUT[31] && busyOn) acqCnt <= 1;
    else if (acqCnt == 13) acqCnt <= 0;
    else if (acqCnt != 0) acqCnt <= acqCnt + 1;
    if (sysCsrStrobe && sysGPIO_OUT[31:29] == 3'b000) lag0 <= binsMem[sysGPIO_OUT[AW-1:0]];
    lag1 <= lag0;
    lag2 <= lag1;
  end

  assign sysCsr = {(acqCnt >= 3), 23'd0, lag2};

  typedef struct packed {
    logic          err;
    logic          to;
    logic [AW-1:0] addr;
    logic [3:0]    cnt;
  } resT;

  logic [31:0] expStrobes[$];
  resT         expResults[$];
  int tests = 0;
  int fails = 0;
  int strobeCount = 0;
  int doneCount = 0;
  int cyc = 0;
  int armCyc = 0;

  // Monitor: pops expectations whenever the DUT strobes or signals done.
  initial begin
    logic [31:0] expWord;
    resT         r;
    logic        prevStrobe;
    logic        prevDone;
    prevStrobe = 1'b0;
    prevDone = 1'b0;
    forever begin
      @(negedge sysClk);
      cyc++;
      if (sysCsrStrobe) begin
        tests++;
        if (prevStrobe) begin
          fails++;
          $display("FAIL strobe_gap: strobe %08h at cycle %0d follows a strobe, required an idle cycle", sysGPIO_OUT, cyc);
        end else if (expStrobes.size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected: got strobe %08h, required no strobe", sysGPIO_OUT);
        end else begin
          expWord = expStrobes.pop_front();
          if (sysGPIO_OUT !== expWord) begin
            fails++;
            $display("FAIL strobe_word: got %08h, required %08h", sysGPIO_OUT, expWord);
          end else begin
            $display("[TB] strobe %08h as expected", sysGPIO_OUT);
          end
        end
        if (sysGPIO_OUT[31]) armCyc = cyc;
        strobeCount++;
      end
      prevStrobe = sysCsrStrobe;
      if (done) begin
        tests++;
        if (prevDone) begin
          fails++;
          $display("FAIL done_width: done high for more than one cycle");
        end else if (expResults.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: got done pulse, required none");
        end else begin
          r = expResults.pop_front();
          if ({error, timedOut, edgeAddress, edgeCount} !== {r.err, r.to, r.addr, r.cnt}) begin
            fails++;
            $display("FAIL result: got err=%0b to=%0b addr=%0d cnt=%0d, required err=%0b to=%0b addr=%0d cnt=%0d",
                     error, timedOut, edgeAddress, edgeCount, r.err, r.to, r.addr, r.cnt);
          end else begin
            $display("[TB] done err=%0b to=%0b addr=%0d cnt=%0d as expected", error, timedOut, edgeAddress, edgeCount);
          end
          tests++;
          if (scanBusy !== 1'b0) begin
            fails++;
            $display("FAIL busy_at_done: scanBusy=%0b, required 0", scanBusy);
          end
          if (r.to) begin
            tests++;
            if (cyc - armCyc < 101 || cyc - armCyc > 103) begin
              fails++;
              $display("FAIL timeout_latency: got %0d cycles from acquire strobe to done, required 101..103", cyc - armCyc);
            end
          end
        end
        doneCount++;
      end
      prevDone = done;
    end
  end

  task automatic checkZero(input string tag);
    tests++;
    if ({sysCsrStrobe, sysGPIO_OUT, scanBusy, done, error, timedOut, edgeAddress, edgeCount} !== '0) begin
      fails++;
      $display("FAIL %s: got strobe=%0b gpio=%08h busy=%0b done=%0b err=%0b to=%0b addr=%0d cnt=%0d, required all 0",
               tag, sysCsrStrobe, sysGPIO_OUT, scanBusy, done, error, timedOut, edgeAddress, edgeCount);
    end else begin
      $display("[TB] %s: outputs all zero", tag);
    end
  endtask

  task automatic waitDone(input int startDone, input string name);
    int n;
    n = 0;
    while (doneCount == startDone && n < 1000) begin
      @(negedge sysClk);
      n++;
    end
    tests++;
    if (doneCount == startDone) begin
      fails++;
      $display("FAIL %s_done_timeout: no done within 1000 cycles, required one", name);
    end else if (expStrobes.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_strobes: %0d expected strobes never seen, required 0", name, expStrobes.size());
      expStrobes.delete();
    end
  endtask

  task automatic runScan(input string name, input logic [63:0] binWord, input logic ch,
                         input logic [AW-1:0] off, input logic rea, input logic busyEn,
                         input logic poke, input logic [AW-1:0] expEdge, input logic [3:0] expCnt,
                         input logic expErr, input logic expTo, input logic [AW-1:0] expProg);
    int            startDone;
    int            n;
    logic [AW-1:0] a;
    resT           r;
    for (int i = 0; i < N; i++) binsMem[i] = binWord[i*8 +: 8];
    busyOn = busyEn;
    expStrobes.push_back(32'h8000_0000);
    if (busyEn) begin
      for (int i = 0; i <= N; i++) begin
        a = (i == 0) ? AW'(N - 1) : AW'(i - 1);
        expStrobes.push_back({7'd0, ch, 21'd0, a});
      end
    end
    if (!expErr) begin
      expStrobes.push_back(32'h4000_0000 | {29'd0, expProg});
      if (rea) expStrobes.push_back(32'h2000_0000);
    end
    r.err = expErr; r.to = expTo; r.addr = expEdge; r.cnt = expCnt;
    expResults.push_back(r);
    startDone = doneCount;
    $display("[TB] run %s start ch=%0d offset=%0d realign=%0b", name, ch, off, rea);
    @(negedge sysClk);
    start = 1'b1; channel = ch; offset = off; realignEnable = rea;
    @(negedge sysClk);
    start = 1'b0; channel = ~ch; offset = ~off; realignEnable = ~rea;
    tests++;
    if (scanBusy !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy: scanBusy=%0b after start, required 1", name, scanBusy);
    end
    if (poke) begin
      n = 0;
      while (sysCsr[31] !== 1'b1 && n < 50) begin
        @(negedge sysClk);
        n++;
      end
      repeat (2) @(negedge sysClk);
      start = 1'b1; channel = 1'b1; offset = 3'd5; realignEnable = 1'b0;
      @(negedge sysClk);
      start = 1'b0;
    end
    waitDone(startDone, name);
    if (poke) begin
      repeat (30) @(negedge sysClk);
      tests++;
      if (doneCount != startDone + 1) begin
        fails++;
        $display("FAIL %s_single_run: got %0d done pulses, required 1", name, doneCount - startDone);
      end
    end
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge sysClk);
    checkZero("reset_state");
    sysReset = 1'b0;
    @(negedge sysClk);
    checkZero("idle_after_reset");

    runScan("basic",     64'h0002070706010000, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 3'd3, 4'd1, 1'b0, 1'b0, 3'd5);
    runScan("modulo",    64'h0700000000000707, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 3'd7, 4'd1, 1'b0, 1'b0, 3'd2);
    runScan("multi",     64'h0000000700070007, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 3'd4, 4'd3, 1'b1, 1'b0, 3'd0);
    runScan("timeout",   64'h0002070706010000, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b1, 3'd0);
    runScan("threshold", 64'h0303030304040303, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 3'd2, 4'd1, 1'b0, 1'b0, 3'd1);
    runScan("midstart",  64'h0002070706010000, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 3'd3, 4'd1, 1'b0, 1'b0, 3'd5);

    // Reset in the middle of the bin readback.
    for (int i = 0; i < N; i++) binsMem[i] = 8'd7;
    busyOn = 1'b1;
    expStrobes.push_back(32'h8000_0000);
    expStrobes.push_back(32'h0000_0007);
    expStrobes.push_back(32'h0000_0000);
    base = strobeCount;
    @(negedge sysClk);
    start = 1'b1; channel = 1'b0; offset = 3'd0; realignEnable = 1'b1;
    @(negedge sysClk);
    start = 1'b0;
    n = 0;
    while (strobeCount < base + 3 && n < 200) begin
      @(negedge sysClk);
      n++;
    end
    tests++;
    if (strobeCount < base + 3) begin
      fails++;
      $display("FAIL reset_setup: got %0d strobes, required 3 before reset", strobeCount - base);
    end
    @(negedge sysClk);
    sysReset = 1'b1;
    expStrobes.delete();
    @(negedge sysClk);
    checkZero("reset_mid_read");
    repeat (2) @(negedge sysClk);
    sysReset = 1'b0;
    repeat (40) @(negedge sysClk);
    checkZero("quiet_after_reset");

    runScan("noedge",    64'h0707070707070707, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd0);
    runScan("wrapedge",  64'h0000000000000005, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 1'b0, 1'b0, 3'd0);

    repeat (5) @(negedge sysClk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coincidence_scanner.md
Name: coincidence_scanner

Overview:
- Hardware sequencer that drives the coincidence recorder's CSR command/readback interface in place of software.
- Sequence per run:
  1. Start an acquisition and wait for it to complete.
  2. Read back one channel's histogram bin by bin.
  3. Locate the single rising edge where the bin count crosses a threshold.
  4. Program the coincidence point to edge + offset (mod bin count).
  5. Optionally request a heartbeat realign.
- Sits in the sysClk domain beside the recorder, and is muxed with the software CSR path.

Parameters:
- SAMPLE_CLKS_PER_COINCIDENCE, 80, histogram bin count N; bin address width AW = $clog2(N).
- SUM_WIDTH, 8, width of one bin count in sysCsr[SUM_WIDTH-1:0].
- MUXSEL_WIDTH, 1, channel-select width (sysGPIO_OUT[24+:MUXSEL_WIDTH]).
- THRESHOLD, 64, bin count at or above this value is "high".
- READ_SETTLE, 16, sysClk cycles from a read-address strobe to sampling sysCsr; covers the two-way clock-crossing plus RAM latency.
- TIMEOUT_CYCLES, 16777215, maximum cycles waiting for busy to rise, and separately to fall.

Ports:
- sysClk  in  1  system clock.
- sysReset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request; ignored unless idle.
- channel  in  MUXSEL_WIDTH  channel to analyse; latched at start.
- offset  in  AW  coincidence offset from edge (< N); latched at start.
- realignEnable  in  1  issue realign command after programming; latched at start.
- sysCsrStrobe  out  1  one-cycle command strobe to recorder.
- sysGPIO_OUT  out  32  command word; valid in strobe cycle, held afterward.
- sysCsr  in  32  recorder status: [31]=busy, [SUM_WIDTH-1:0]=bin count.
- scanBusy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of run (success or failure).
- error  out  1  result flag, valid from done until next start: timeout, or edge count != 1.
- timedOut  out  1  result flag: failure was a timeout.
- edgeAddress  out  AW  address of last rising edge found.
- edgeCount  out  4  rising edges found, saturating at 15.

Behaviour:
- Reset values: all outputs 0; state IDLE; sysGPIO_OUT 0.
- Strobe rules:
  - Every command is exactly one sysCsrStrobe cycle with sysGPIO_OUT set in that same cycle.
  - At least one non-strobe cycle separates consecutive strobes.
  - Unused sysGPIO_OUT bits are 0.
- IDLE: on start, latch channel, offset and realignEnable; clear edgeCount, edgeAddress, error, timedOut; raise scanBusy; go to ARM.
- ARM: strobe with sysGPIO_OUT[31]=1; clear timer; go to WAIT_RISE.
- WAIT_RISE:
  - sysCsr[31]=1 -> clear timer, go to WAIT_FALL.
  - Timer reaches TIMEOUT_CYCLES -> error=1, timedOut=1, go to FINISH.
- WAIT_FALL:
  - sysCsr[31]=0 -> set readIndex=0, go to READ_REQ.
  - Timeout handled as in WAIT_RISE.
- READ_REQ:
  - Strobe with sysGPIO_OUT[30:29]=0, [31]=0, [24+:MUXSEL_WIDTH]=channel, [0+:AW]=addr.
  - addr = N-1 when readIndex=0, else readIndex-1.
  - Go to READ_WAIT.
- READ_WAIT: wait exactly READ_SETTLE cycles after the strobe, then sample sysCsr[SUM_WIDTH-1:0] as the bin value.
- Edge detection:
  - hi = (value >= THRESHOLD).
  - readIndex=0 only primes prevHi.
  - For readIndex >= 1: if hi && !prevHi, then edgeAddress=addr and edgeCount increments (saturating).
  - prevHi <= hi.
  - Reading N+1 bins total (N-1, then 0..N-1) handles the wrap edge at address 0.
- Loop: readIndex increments; after readIndex=N go to EVAL, otherwise back to READ_REQ.
- EVAL:
  - edgeCount != 1 -> error=1, go to FINISH; no coincidence write is issued.
  - Otherwise go to PROGRAM.
- PROGRAM: strobe with [30]=1 and [0+:AW]=(edgeAddress+offset) mod N, computed at AW+1 bits with a conditional subtract of N.
- After PROGRAM:
  - realignEnable=1 -> REALIGN: strobe with [29]=1 only.
  - Otherwise go to FINISH.
- FINISH: done=1 for one cycle, scanBusy=0, return to IDLE. Result outputs hold until the next start.
- start while scanBusy: ignored, no queuing. start in the same cycle as FINISH: ignored.
- sysReset mid-run: immediate return to IDLE with outputs cleared. No strobe is emitted during or after reset. A recorder acquisition already started is not cancelled.

Test Plan (bench overrides N=8, THRESHOLD=4, READ_SETTLE=4, TIMEOUT_CYCLES=100; the recorder model returns sysCsr bins after a 4-cycle lag):
- Bins {0,0,1,6,7,7,2,0}, offset=2, realignEnable=1 -> strobes in order: [31]; 9 reads at addresses 7,0..7; [30] with addr 5; [29]. edgeAddress=3, edgeCount=1, error=0, one done pulse.
- Bins {7,7,0,0,0,0,0,7}, offset=3 -> edge at address 7; programmed addr (7+3) mod 8=2; exercises the modulo path.
- Bins {7,0,7,0,7,0,0,0} -> edgeCount=3, error=1, timedOut=0; no [30] or [29] strobe.
- Busy never rises -> done at cycle ~101 after ARM strobe; error=1, timedOut=1; no read strobes.
- Start pulsed during WAIT_FALL -> ignored, single run. sysReset asserted during READ_WAIT -> all outputs 0 next edge, no further strobes. A subsequent start then runs cleanly.
- Bins all 7 (no edge) -> edgeCount=0, error=1; the wrap read of address 7 does not create a false edge.
